// File: rtl/arith_pkg.sv
// Shared arithmetic helpers: ALU op encoding, slice geometry, 1-bit full adder.
// Latency: none (package of constants and pure functions).
// Backpressure: not applicable.
package arith_pkg;

    // Encoding driven onto the adder's sub input by the ALU decoder
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Bits handled by each pipeline stage; guarded so a bad STAGES never divides by zero
    function automatic int slice_width(input int width, input int stages);
        return (stages >= 1) ? (width / stages) : width;
    endfunction

    // Geometry is legal when every stage gets an equal, non-empty slice
    function automatic bit geometry_ok(input int width, input int stages);
        return (stages >= 1) && (width >= 2) && ((width % stages) == 0);
    endfunction

    // Returns {carry_out, sum}
    function automatic logic [1:0] full_adder(input logic a, input logic b, input logic ci);
        return {(a & b) | (ci & (a ^ b)), a ^ b ^ ci};
    endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational SLICE-bit ripple-carry adder built from full_adder cells.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the enclosing pipeline stage decides when to register the result.
module adder_slice
    import arith_pkg::*;
#(
    parameter int SLICE = 8
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             ci,
    output logic [SLICE-1:0] s,
    output logic             co
);

    logic [SLICE:0] c;

    // Ripple the carry LSB to MSB through one full adder per bit
    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < SLICE; i++) begin
            {c[i+1], s[i]} = full_adder(a[i], b[i], c[i]);
        end
        co = c[SLICE];
    end

endmodule

// File: rtl/pipelined_adder_sub.sv
// Pipelined two's-complement add/sub; carry chain cut into STAGES registered slices.
// Latency: STAGES cycles from input transfer to out_valid; one op per cycle when out_ready=1.
// Backpressure: elastic valid/ready, in_ready combinational from out_ready (no skid buffer).
module pipelined_adder_sub
    import arith_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             Cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf,
    output logic             Zero
);

    localparam int SLICE = slice_width(WIDTH, STAGES);

    generate
        if (!geometry_ok(WIDTH, STAGES)) begin : g_bad_geometry
            $error("pipelined_adder_sub: WIDTH must be >= 2 and a multiple of STAGES >= 1");
        end
    endgenerate

    // Index k = what stage k sees: 0 is the raw input, k>0 is stage k-1's register.
    // Operands are shifted right by SLICE each stage so the next slice is always at [SLICE-1:0].
    logic [WIDTH-1:0] x_b [STAGES];
    logic [WIDTH-1:0] y_b [STAGES];
    logic [WIDTH-1:0] s_b [STAGES];   // lower Sum slices already computed
    logic             c_b [STAGES];   // carry into stage k
    logic [SLICE-1:0] ss  [STAGES];   // slice sum of stage k
    logic             sc  [STAGES];   // slice carry-out of stage k

    logic [STAGES-1:0] v;      // stage k register holds a live op
    logic [STAGES-1:0] vin;    // valid arriving at stage k
    logic [STAGES:0]   load;   // stage k may capture this cycle

    // Subtraction is X + ~Y + 1, with a borrow-in cancelling that +1
    assign x_b[0] = X;
    assign y_b[0] = (sub == OP_SUB) ? ~Y : Y;
    assign c_b[0] = (sub == OP_SUB) ? ~Cin : Cin;
    assign s_b[0] = '0;

    assign vin       = (v << 1) | STAGES'(in_valid);
    assign in_ready  = load[0];
    assign out_valid = v[STAGES-1];

    // A stage loads when empty or when its successor is loading; walk from the output back
    always_comb begin
        load         = '0;
        load[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            load[k] = !v[k] || load[k+1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        adder_slice #(.SLICE(SLICE)) u_slice (
            .a  (x_b[k][SLICE-1:0]),
            .b  (y_b[k][SLICE-1:0]),
            .ci (c_b[k]),
            .s  (ss[k]),
            .co (sc[k])
        );

        if (k < STAGES - 1) begin : g_mid
            logic             v_q;
            logic             c_q;
            logic [WIDTH-1:0] x_q;
            logic [WIDTH-1:0] y_q;
            logic [WIDTH-1:0] s_q;

            // Capture slice result and remaining operands; data only moves with a live op
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    v_q <= 1'b0;
                    c_q <= 1'b0;
                    x_q <= '0;
                    y_q <= '0;
                    s_q <= '0;
                end else begin
                    if (load[k]) v_q <= vin[k];
                    if (load[k] && vin[k]) begin
                        c_q <= sc[k];
                        x_q <= x_b[k] >> SLICE;
                        y_q <= y_b[k] >> SLICE;
                        s_q <= s_b[k] | (WIDTH'(ss[k]) << (k * SLICE));
                    end
                end
            end

            assign v[k]     = v_q;
            assign c_b[k+1] = c_q;
            assign x_b[k+1] = x_q;
            assign y_b[k+1] = y_q;
            assign s_b[k+1] = s_q;
        end else begin : g_last
            logic             v_q;
            logic [WIDTH-1:0] sum_full;
            logic             ovf_c;

            // The top slice is in the low bits here, so bit SLICE-1 is the operand sign
            assign sum_full = s_b[k] | (WIDTH'(ss[k]) << (k * SLICE));
            assign ovf_c    = (x_b[k][SLICE-1] == y_b[k][SLICE-1]) &&
                              (ss[k][SLICE-1] != x_b[k][SLICE-1]);

            // Output register: flags are computed from the same sum they are stored with
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    v_q  <= 1'b0;
                    Sum  <= '0;
                    Cout <= 1'b0;
                    Ovf  <= 1'b0;
                    Zero <= 1'b0;
                end else begin
                    if (load[k]) v_q <= vin[k];
                    if (load[k] && vin[k]) begin
                        Sum  <= sum_full;
                        Cout <= sc[k];
                        Ovf  <= ovf_c;
                        Zero <= ~|sum_full;
                    end
                end
            end

            assign v[k] = v_q;
        end
    end

endmodule

// File: tb/tb_pipelined_adder_sub.sv
// Self-checking bench: 32/4, 8/1 and 12/3 instances share one stimulus stream.
// Latency: each instance's results are scoreboarded with a STAGES-cycle latency check.
// Backpressure: only the 32-bit instance sees out_ready toggled; the others always accept.
module tb_pipelined_adder_sub;
    import arith_pkg::*;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
        int          cyc;
        bit          lat;
    } exp_t;

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic        cin;
        logic        sb;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid;
    logic [31:0] x_in, y_in;
    logic        cin_in, sub_in;
    logic        ordy0;

    logic        rdy0, ov0, co0, of0, z0;
    logic [31:0] s0;
    logic        rdy1, ov1, co1, of1, z1;
    logic [7:0]  s1;
    logic        rdy2, ov2, co2, of2, z2;
    logic [11:0] s2;

    pipelined_adder_sub #(.WIDTH(32), .STAGES(4)) dut32 (
        .clk(clk), .reset_n(rst_n), .in_valid(in_valid), .in_ready(rdy0),
        .X(x_in), .Y(y_in), .Cin(cin_in), .sub(sub_in),
        .out_valid(ov0), .out_ready(ordy0), .Sum(s0), .Cout(co0), .Ovf(of0), .Zero(z0)
    );

    pipelined_adder_sub #(.WIDTH(8), .STAGES(1)) dut8 (
        .clk(clk), .reset_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
        .X(x_in[7:0]), .Y(y_in[7:0]), .Cin(cin_in), .sub(sub_in),
        .out_valid(ov1), .out_ready(1'b1), .Sum(s1), .Cout(co1), .Ovf(of1), .Zero(z1)
    );

    pipelined_adder_sub #(.WIDTH(12), .STAGES(3)) dut12 (
        .clk(clk), .reset_n(rst_n), .in_valid(in_valid), .in_ready(rdy2),
        .X(x_in[11:0]), .Y(y_in[11:0]), .Cin(cin_in), .sub(sub_in),
        .out_valid(ov2), .out_ready(1'b1), .Sum(s2), .Cout(co2), .Ovf(of2), .Zero(z2)
    );

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   lat_on;
    exp_t cur_exp;
    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    exp_t e0, e1, e2;

    always @(posedge clk) cyc <= cyc + 1;

    // Whole-word reference: {Cout,Sum} = X + Yeff + c0 on w bits
    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y,
                                   input logic cin, input logic sb, input int w);
        logic [63:0] mask, xm, ye, full;
        exp_t e;
        mask   = (64'd1 << w) - 64'd1;
        xm     = {32'd0, x} & mask;
        ye     = {32'd0, ((sb == OP_SUB) ? ~y : y)} & mask;
        full   = xm + ye + ((sb == OP_SUB) ? {63'd0, ~cin} : {63'd0, cin});
        e.sum  = full[31:0] & mask[31:0];
        e.cout = full[w];
        e.ovf  = (xm[w-1] == ye[w-1]) && (full[w-1] != xm[w-1]);
        e.zero = (e.sum == 32'd0);
        e.cyc  = 0;
        e.lat  = 1'b1;
        return e;
    endfunction

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, req);
        end
    endtask

    task automatic chk_out(input string dut, input logic [31:0] s, input logic c,
                           input logic o, input logic z, input exp_t e, input int stages);
        check({dut, ".Sum"}, s, e.sum);
        check({dut, ".Cout"}, 32'(c), 32'(e.cout));
        check({dut, ".Ovf"}, 32'(o), 32'(e.ovf));
        check({dut, ".Zero"}, 32'(z), 32'(e.zero));
        if (e.lat) check({dut, ".latency"}, 32'(cyc - e.cyc), 32'(stages));
    endtask

    // Scoreboards: push on input transfer, pop and compare on output transfer
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && rdy0) begin
                e0 = cur_exp; e0.cyc = cyc; e0.lat = lat_on;
                q0.push_back(e0);
            end
            if (ov0 && ordy0) begin
                if (q0.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL dut32 phantom: got output Sum=0x%0h, expected none", s0);
                end else chk_out("dut32", s0, co0, of0, z0, q0.pop_front(), 4);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && rdy1) begin
                e1 = model(x_in, y_in, cin_in, sub_in, 8); e1.cyc = cyc;
                q1.push_back(e1);
            end
            if (ov1) begin
                if (q1.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL dut8 phantom: got output Sum=0x%0h, expected none", s1);
                end else chk_out("dut8", 32'(s1), co1, of1, z1, q1.pop_front(), 1);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && rdy2) begin
                e2 = model(x_in, y_in, cin_in, sub_in, 12); e2.cyc = cyc;
                q2.push_back(e2);
            end
            if (ov2) begin
                if (q2.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL dut12 phantom: got output Sum=0x%0h, expected none", s2);
                end else chk_out("dut12", 32'(s2), co2, of2, z2, q2.pop_front(), 3);
            end
        end
    end

    // Present one op for one cycle; called and returns at posedge+1
    task automatic send(input logic [31:0] x, input logic [31:0] y, input logic c,
                        input logic sb, input exp_t e, output bit acc);
        x_in = x; y_in = y; cin_in = c; sub_in = sb; cur_exp = e;
        in_valid = 1'b1;
        @(negedge clk);
        acc = rdy0;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while ((q0.size() + q1.size() + q2.size()) != 0 && n < 200) begin
            @(posedge clk); n++;
        end
        repeat (3) @(posedge clk);
        #1;
        check({nm, " pending results"}, 32'(q0.size() + q1.size() + q2.size()), 32'd0);
    endtask

    task automatic chk_reset(input string nm);
        check({nm, " dut32 out_valid"}, 32'(ov0), 32'd0);
        check({nm, " dut32 Sum"}, s0, 32'd0);
        check({nm, " dut32 flags"}, {29'd0, co0, of0, z0}, 32'd0);
        check({nm, " dut8 out_valid/Sum/flags"}, {20'd0, ov1, s1, co1, of1, z1}, 32'd0);
        check({nm, " dut12 out_valid/Sum/flags"}, {16'd0, ov2, s2, co2, of2, z2}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[11];
        exp_t e;
        bit   acc;
        int   nacc;
        logic [31:0] rx, ry;
        logic rc, rs;

        tbl[0]  = '{32'h0000_0005, 32'h0000_0003, 1'b0, OP_ADD, 32'h0000_0008, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, OP_ADD, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        tbl[2]  = '{32'h8000_0000, 32'h0000_0001, 1'b0, OP_SUB, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
        tbl[3]  = '{32'h0000_0003, 32'h0000_0005, 1'b0, OP_SUB, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, OP_ADD, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{32'h0000_0005, 32'h0000_0005, 1'b0, OP_SUB, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        tbl[6]  = '{32'h0000_000A, 32'h0000_0014, 1'b1, OP_ADD, 32'h0000_001F, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{32'h0000_000A, 32'h0000_0003, 1'b1, OP_SUB, 32'h0000_0006, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{32'h0000_0000, 32'h0000_0001, 1'b0, OP_SUB, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, OP_ADD, 32'h0001_0000, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{32'h8000_0000, 32'h8000_0000, 1'b0, OP_ADD, 32'h0000_0000, 1'b1, 1'b1, 1'b1};

        rst_n = 1'b0; in_valid = 1'b0; x_in = '0; y_in = '0; cin_in = 1'b0; sub_in = OP_ADD;
        ordy0 = 1'b1; lat_on = 1'b1; cur_exp = model(32'd0, 32'd0, 1'b0, 1'b0, 32);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_reset("reset");
        check("reset in_ready", 32'(rdy0), 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors, back to back
        foreach (tbl[i]) begin
            e.sum = tbl[i].sum; e.cout = tbl[i].cout; e.ovf = tbl[i].ovf; e.zero = tbl[i].zero;
            e.cyc = 0; e.lat = 1'b1;
            send(tbl[i].x, tbl[i].y, tbl[i].cin, tbl[i].sb, e, acc);
            check($sformatf("table[%0d] accepted", i), 32'(acc), 32'd1);
        end
        drain("table");

        // Streaming: 100 back-to-back random ops
        for (int i = 0; i < 100; i++) begin
            rx = $urandom; ry = $urandom; rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
            send(rx, ry, rc, rs, model(rx, ry, rc, rs, 32), acc);
            if (!acc) check($sformatf("stream[%0d] accepted", i), 32'(acc), 32'd1);
        end
        drain("stream");

        // Random ops with idle gaps
        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                @(posedge clk); #1;
            end
            rx = $urandom; ry = $urandom; rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
            send(rx, ry, rc, rs, model(rx, ry, rc, rs, 32), acc);
        end
        drain("gaps");

        // Back-pressure: fill with out_ready low
        ordy0 = 1'b0; lat_on = 1'b0; nacc = 0;
        for (int i = 0; i < 6; i++) begin
            rx = $urandom; ry = $urandom; rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
            send(rx, ry, rc, rs, model(rx, ry, rc, rs, 32), acc);
            if (acc) nacc++;
        end
        check("backpressure accepted count", 32'(nacc), 32'd4);
        check("backpressure queued", 32'(q0.size()), 32'd4);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall in_ready", 32'(rdy0), 32'd0);
            check("stall out_valid", 32'(ov0), 32'd1);
            check("stall Sum", s0, q0[0].sum);
            check("stall flags", {29'd0, co0, of0, z0}, {29'd0, q0[0].cout, q0[0].ovf, q0[0].zero});
        end
        @(posedge clk); #1;
        ordy0 = 1'b1;
        drain("release");
        lat_on = 1'b1;

        // Reset with ops in flight
        for (int i = 0; i < 3; i++) begin
            rx = $urandom; ry = $urandom;
            send(rx, ry, 1'b0, OP_ADD, model(rx, ry, 1'b0, OP_ADD, 32), acc);
        end
        check("pre-reset in flight", 32'(q0.size()), 32'd3);
        rst_n = 1'b0;
        #1;
        chk_reset("midreset");
        q0.delete(); q1.delete(); q2.delete();
        repeat (2) @(posedge clk);
        #1;
        chk_reset("reset held");
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post-reset dut32 out_valid", 32'(ov0), 32'd0);
        send(32'h1234_5678, 32'h0F0F_0F0F, 1'b1, OP_SUB, model(32'h1234_5678, 32'h0F0F_0F0F, 1'b1, OP_SUB, 32), acc);
        check("post-reset accepted", 32'(acc), 32'd1);
        drain("post-reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
